regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of writeback requesters.
REQ-002 Parameter XLEN, default 32, SHALL set the data width.
REQ-003 Parameter REG_ADDR_W, default 5, SHALL set the register address width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  SHALL carry the per-requester writeback request.
REQ-007 req_rd  in  NUM_REQ*REG_ADDR_W  SHALL carry the per-requester destination register, packed with requester i at bits [i*5 +: 5].
REQ-008 req_data  in  NUM_REQ*XLEN  SHALL carry the per-requester write data, packed with requester i at bits [i*XLEN +: XLEN].
REQ-009 req_ready  out  NUM_REQ  SHALL carry the per-requester accept, one-hot or zero.
REQ-010 rsv_valid  in  1  SHALL be the issue-stage destination reservation strobe.
REQ-011 rsv_rd  in  REG_ADDR_W  SHALL be the register being reserved.
REQ-012 rf_regWrite  out  1  SHALL be the register-file write enable.
REQ-013 rf_rd  out  REG_ADDR_W  SHALL be the register-file write address.
REQ-014 rf_writeData  out  XLEN  SHALL be the register-file write data.
REQ-015 grant_id  out  clog2(NUM_REQ)  SHALL identify the requester whose write is on rf_* this cycle.
REQ-016 busy  out  32  SHALL be the pending-write scoreboard, with bit n meaning register n is awaiting writeback.

Function
REQ-017 Arbitration SHALL be round-robin. Priority pointer ptr SHALL start at requester ptr, then ptr+1 mod NUM_REQ, and so on; the first requester with valid set wins.
REQ-018 req_ready[i] SHALL be combinational: 1 only for the winner in that cycle, 0 for all others. Requesters SHALL NOT make valid depend on ready.
REQ-019 A handshake is valid&ready at a clock edge. On a handshake, ptr SHALL become winner+1 mod NUM_REQ; with no handshake, ptr SHALL hold.
REQ-020 Latency SHALL be 1 cycle: a handshake at edge N drives rf_rd, rf_writeData and grant_id from edge N, and asserts rf_regWrite for exactly the cycle after edge N.
REQ-021 Throughput SHALL be one accepted write per cycle. There is no backpressure from the register file.
REQ-022 A request with rd=0 SHALL complete its handshake and advance ptr, but rf_regWrite SHALL stay 0 for it.
REQ-023 With no handshake, rf_regWrite SHALL be 0 next cycle; rf_rd, rf_writeData and grant_id SHALL hold their last values.
REQ-024 rsv_valid with rsv_rd!=0 SHALL set busy[rsv_rd] at the next edge.
REQ-025 A cycle with rf_regWrite=1 SHALL clear busy[rf_rd] at the next edge.
REQ-026 Simultaneous set and clear of the same bit SHALL resolve with set winning, since the newer reservation dominates.
REQ-027 busy[0] SHALL be constant 0. rsv_rd=0 SHALL be ignored.
REQ-028 Clearing an already-clear bit SHALL be harmless and SHALL raise no error.
REQ-029 A requester holding valid SHALL be granted within NUM_REQ cycles, so there is no starvation.

Reset
REQ-030 While rst=1, regardless of clk: req_ready=0, rf_regWrite=0, rf_rd=0, rf_writeData=0, grant_id=0, busy=0, ptr=0.
REQ-031 Reset asserted mid-operation SHALL discard any registered write: no rf_regWrite pulse after rst rises, and none in the first cycle after release.
REQ-032 Arbitration SHALL resume at the first edge after rst falls, with requester 0 at top priority.

Structure
REQ-033 Package regfile_pkg SHALL hold XLEN, REG_ADDR_W, NUM_REGS=32, NUM_REQ and REQ_ID_W, shared with the register file and the datapath.
REQ-034 The round-robin grant logic and pointer SHALL live in sub-module rr_arbiter (params N; in req, out grant one-hot, out grant_idx, in advance).
REQ-035 The scoreboard and the output register stage SHALL be in regfile_wb_arbiter itself.

Verification
REQ-036 Single request: valid=001, rd=5, data=0xDEADBEEF -> ready=001 same cycle; next cycle rf_regWrite=1, rf_rd=5, rf_writeData=0xDEADBEEF, grant_id=0.
REQ-037 All three requesters held valid for 6 cycles from reset -> grant order 0,1,2,0,1,2, one rf_regWrite pulse per cycle.
REQ-038 Requester 1 valid with rd=0, data=0x1234 -> ready[1]=1 and ptr advances to 2, but rf_regWrite stays 0.
REQ-039 rsv_valid with rsv_rd=7 -> busy[7]=1; a later write to rd=7 clears busy[7]; in a cycle where rsv_rd=7 coincides with an rf_regWrite to 7, busy[7] remains 1.
REQ-040 Handshake to rd=9 at edge N, then rst pulsed asynchronously before edge N+1 -> rf_regWrite never pulses, and busy, ptr and grant_id are 0 after release.
REQ-041 rsv_valid with rsv_rd=0 -> busy stays 0x00000000.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose: shared register-file / writeback widths used by the arbiter, register file and datapath.
// Latency: none (constants only).
// Backpressure: none (constants only).
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int NUM_REQ    = 3;
    // A single requester still needs a 1-bit id field.
    localparam int REQ_ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin grant among N requesters; the pointer moves past the winner on advance.
// Latency: grant/grant_idx are combinational from req and the pointer; the pointer updates at the edge.
// Backpressure: none internally; the pointer holds unless advance is asserted.
//
// Ports: clk, rst (async, active-high); req[N] in; grant[N] one-hot out;
//        grant_idx out (index of the winner); advance in (winner was accepted this cycle).
module rr_arbiter #(
    parameter int N = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    input  logic             advance
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;
    logic             found;

    // Scan from the pointer upward with wrap; ptr + i < 2N always fits in IDX_W+1 bits.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates writeback requesters onto one register-file write port and tracks pending writes.
// Latency: req_ready is combinational; rf_* outputs appear one cycle after the handshake.
// Backpressure: exactly one requester is accepted per cycle; the register file never stalls.
//
// Ports: clk, rst (async, active-high);
//        req_valid/req_rd/req_data in, req_ready out (per requester, packed by index);
//        rsv_valid/rsv_rd in (issue-stage destination reservation);
//        rf_regWrite/rf_rd/rf_writeData out (register-file write port), grant_id out;
//        busy out (bit n set while register n awaits its writeback).
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = regfile_pkg::NUM_REQ,
    parameter int XLEN       = regfile_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]      req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         rsv_valid,
    input  logic [REG_ADDR_W-1:0]        rsv_rd,
    output logic                         rf_regWrite,
    output logic [REG_ADDR_W-1:0]        rf_rd,
    output logic [XLEN-1:0]              rf_writeData,
    output logic [ID_W-1:0]              grant_id,
    output logic [31:0]                  busy
);

    import regfile_pkg::*;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  handshake;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  wr_en_q,  wr_en_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    logic [XLEN-1:0]       data_q,   data_d;
    logic [ID_W-1:0]       gid_q,    gid_d;
    logic [NUM_REGS-1:0]   busy_q,   busy_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .advance   (handshake)
    );

    // Ready must read zero while reset is held, independent of the clock.
    assign req_ready = grant & {NUM_REQ{~rst}};
    assign handshake = |req_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        // x0 writes still consume a slot and advance the pointer, but never reach the file.
        wr_en_d = handshake && (sel_rd != '0);
        rd_d    = handshake ? sel_rd    : rd_q;
        data_d  = handshake ? sel_data  : data_q;
        gid_d   = handshake ? grant_idx : gid_q;

        // Clear first, then set: a same-cycle reservation of the register being written wins.
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            busy_q  <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_regWrite  = wr_en_q;
    assign rf_rd        = rd_q;
    assign rf_writeData = data_q;
    assign grant_id     = gid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic        rf_regWrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_writeData;
    logic [1:0]  grant_id;
    logic [31:0] busy;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsv_valid    (rsv_valid),
        .rsv_rd       (rsv_rd),
        .rf_regWrite  (rf_regWrite),
        .rf_rd        (rf_rd),
        .rf_writeData (rf_writeData),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;
    logic [1:0]  m_gid  = '0;
    logic [31:0] m_busy = '0;

    function automatic int winner(input int p, input logic [2:0] v);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_rd = '0; m_data = '0; m_gid = '0; m_busy = '0;
        end else begin
            logic [31:0] nb;
            int w;
            nb = m_busy;
            if (m_we) nb[m_rd] = 1'b0;
            if (rsv_valid && rsv_rd != 5'd0) nb[rsv_rd] = 1'b1;
            nb[0] = 1'b0;
            w = winner(m_ptr, req_valid);
            m_we = 1'b0;
            if (w >= 0) begin
                m_rd   = req_rd[w*5 +: 5];
                m_data = req_data[w*32 +: 32];
                m_gid  = w[1:0];
                m_we   = (m_rd != 5'd0);
                m_ptr  = (w + 1) % NR;
            end
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        int w;
        logic [2:0] exp_rdy;
        w = winner(m_ptr, req_valid);
        exp_rdy = (rst || w < 0) ? 3'b000 : (3'b001 << w);
        chk("cyc_req_ready", req_ready, exp_rdy);
        chk("cyc_rf_regWrite", rf_regWrite, m_we);
        chk("cyc_rf_rd", rf_rd, m_rd);
        chk("cyc_rf_writeData", rf_writeData, m_data);
        chk("cyc_grant_id", grant_id, m_gid);
        chk("cyc_busy", busy, m_busy);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        req_rd[i*5 +: 5]    = rd;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsv_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0; rsv_valid = 1'b0; rsv_rd = '0;
        step();
        step();
        chk("reset_busy", busy, 32'h0);
        chk("reset_regWrite", rf_regWrite, 1'b0);
        rst = 1'b0;

        // single request
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1 chk("single_ready", req_ready, 3'b001);
        step();
        req_valid = '0;
        chk("single_we", rf_regWrite, 1'b1);
        chk("single_rd", rf_rd, 5'd5);
        chk("single_data", rf_writeData, 32'hDEADBEEF);
        chk("single_gid", grant_id, 2'd0);
        step();
        chk("idle_we", rf_regWrite, 1'b0);
        chk("idle_rd_hold", rf_rd, 5'd5);

        // all three held valid from reset
        do_reset();
        set_req(0, 5'd1, 32'h100);
        set_req(1, 5'd2, 32'h200);
        set_req(2, 5'd3, 32'h300);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_order", grant_id, order[k]);
            chk("rr_we", rf_regWrite, 1'b1);
        end
        req_valid = '0;

        // rd=0 completes but does not write; pointer moves to 2
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b010;
        #1 chk("x0_ready", req_ready, 3'b010);
        step();
        chk("x0_we", rf_regWrite, 1'b0);
        chk("x0_gid", grant_id, 2'd1);
        chk("x0_data", rf_writeData, 32'h1234);
        req_valid = 3'b111;
        #1 chk("x0_ptr_next", req_ready, 3'b100);
        req_valid = '0;

        // scoreboard
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        step();
        rsv_valid = 1'b0;
        chk("rsv7_set", busy, 32'h80);
        set_req(0, 5'd7, 32'hAAAA0007);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        chk("wr7_we", rf_regWrite, 1'b1);
        chk("wr7_rd", rf_rd, 5'd7);
        step();
        chk("wr7_clear", busy, 32'h0);
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        step();
        rsv_valid = 1'b0;
        req_valid = 3'b001;
        step();
        req_valid = '0;
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        step();
        rsv_valid = 1'b0;
        chk("set_beats_clear", busy, 32'h80);
        set_req(0, 5'd8, 32'h8888);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step();
        chk("clear_clean_bit", busy, 32'h80);

        // rsv to x0 ignored
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        step();
        rsv_valid = 1'b0;
        chk("rsv0_ignored", busy, 32'h0);

        // reset mid-operation discards the registered write
        set_req(0, 5'd9, 32'h99);
        set_req(2, 5'd4, 32'h44);
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        req_valid = 3'b001;
        step();
        rsv_valid = 1'b0;
        req_valid = 3'b101;
        #1 rst = 1'b1;
        #1;
        chk("rst_we", rf_regWrite, 1'b0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_ready", req_ready, 3'b000);
        #1 rst = 1'b0;
        #2;
        chk("rel_ready_ptr0", req_ready, 3'b001);
        chk("rel_gid", grant_id, 2'd0);
        chk("rel_we", rf_regWrite, 1'b0);
        chk("rel_busy", busy, 32'h0);
        step();
        req_valid = '0;
        chk("resume_gid", grant_id, 2'd0);
        chk("resume_rd", rf_rd, 5'd9);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
